hop_word_deser: RTL
===================

# hop_word_deser

Bit-serial HOP word receiver for the memory module/sector path. It samples a serial HOP frame one bit per bit-time strobe and assembles it in a shift register. It then presents the decoded parallel fields (instruction module/sector, syllable, instruction address, data module/sector, duplex flags) through a valid/acknowledge holding register. It sits between the serial HOP transmitter and the memory address select logic, and is the receiving end of the serial HOPC1 stream.

## Interface
Parameters:
- FRAME_BITS, 26, data bits per HOP frame, excluding parity. Fixed at 26; the field map below depends on it.

Ports:
- CLK  in  1  system clock; all state changes on its rising edge.
- RST  in  1  synchronous, active-high reset.
- BTE  in  1  bit-time enable; HOPD and START are sampled only in cycles with BTE=1.
- START  in  1  frame start; qualified by BTE, marks the cycle in which HOPD carries bit 0.
- HOPD  in  1  serial HOP data, LSB first.
- HOP_ACK  in  1  consumer acknowledge; clears HOP_VALID.
- HOP_VALID  out  1  holding register contains an unacknowledged word.
- IM  out  3  instruction module, frame bits 0-2.
- IS  out  4  instruction sector, frame bits 3-6.
- SYL  out  1  syllable, frame bit 7.
- IA  out  8  instruction address, frame bits 8-15.
- DM  out  3  data module, frame bits 16-18.
- DS  out  4  data sector, frame bits 19-22.
- DUPIN  out  1  instruction duplex, frame bit 23.
- DUPDN  out  1  data duplex, frame bit 24.
- (Frame bit 25 is spare: received, then discarded.)
- BUSY  out  1  frame reception in progress.
- OVERRUN  out  1  sticky; a completed frame was dropped.
- FRAME_ERR  out  1  one-cycle pulse; START arrived mid-frame.
- PAR_ERR  out  1  parity error flag (present only with the macro; tied 0 otherwise).

## Operation
- State machine: IDLE, SHIFT. A word completes on the strobe of its last bit.
- In IDLE, BTE&START: bit 0 is captured from HOPD, the bit counter is set to 1, and the state goes to SHIFT. BTE without START: no change. START without BTE: ignored.
- In SHIFT, each BTE cycle captures HOPD at the counter position and increments the counter. The counter is 5 bits and never wraps past the last bit index.
- Last bit captured (index FRAME_BITS-1, or FRAME_BITS with parity): the word is committed and the state returns to IDLE.
- START&BTE during SHIFT: the partial frame is discarded, FRAME_ERR pulses for one cycle, and reception restarts with the current HOPD as bit 0. State stays SHIFT.
- Commit rules:
  - HOP_VALID=0: load the holding register and set HOP_VALID.
  - HOP_VALID=1 and HOP_ACK=1 in the same cycle: load the new word and keep HOP_VALID=1. OVERRUN is not set.
  - HOP_VALID=1 and HOP_ACK=0: drop the new word, keep the old word, and set OVERRUN.
- HOP_ACK with no commit in the same cycle: clears HOP_VALID and OVERRUN. HOP_ACK while HOP_VALID=0 has no effect.
- Field outputs are driven from the holding register only. They stay stable while HOP_VALID=1 and hold their last value after ACK.
- BUSY=1 exactly when the state is SHIFT.

## Timing
- Reset: state IDLE, counter 0, shift register 0, holding register 0, and all outputs 0.
- RST mid-frame aborts the frame with no commit and no FRAME_ERR.
- Latency: HOP_VALID rises and the fields update on the clock edge that samples the final bit. They are visible in the cycle after the final BTE strobe.
- HOP_ACK sampled at edge N: HOP_VALID is low after edge N.
- FRAME_ERR is high for exactly the one cycle following the offending strobe.
- BTE may be arbitrarily sparse. Gaps between strobes do not affect the result.

## Configuration
- HOP_PARITY_EN defined:
  - The frame carries 27 bits; bit 26 is an odd-parity bit over bits 0-26.
  - On commit, PAR_ERR is set if the count of ones is even, and cleared if odd.
  - PAR_ERR is updated on every accepted commit and held with the word.
  - A word that fails parity still commits normally (HOP_VALID=1).
- HOP_PARITY_EN undefined: the frame is 26 bits and PAR_ERR is constant 0.

## Test plan
- Reset, then a frame of 0xBA3CD5 (plus parity bit 1 if enabled) with BTE every 3rd cycle -> IM=5, IS=0xA, SYL=1, IA=0x3C, DM=2, DS=7, DUPIN=1, DUPDN=0, HOP_VALID=1 one cycle after the final strobe; PAR_ERR=0.
- Second frame of 0x1FFFFFF completes while HOP_VALID=1 and no ACK -> fields still decode 0xBA3CD5, OVERRUN=1; then ACK -> HOP_VALID=0, OVERRUN=0.
- Frame completes in the same cycle as HOP_ACK -> new word loaded, HOP_VALID stays 1, OVERRUN=0.
- START&BTE at bit 10 of a frame -> FRAME_ERR pulses for 1 cycle; the following 26 strobes commit the restarted word only.
- RST asserted at bit 12, then a clean frame -> no commit from the aborted frame, and the clean frame decodes correctly.
- With HOP_PARITY_EN: frame 0xBA3CD5 with parity bit 0 -> HOP_VALID=1, PAR_ERR=1.

Source files
------------

// File: rtl/hop_word_deser.sv
// Bit-serial HOP word receiver: assembles an LSB-first frame and presents its fields through
// a valid/ack holding register. Define HOP_PARITY_EN for a 27-bit frame with odd parity.
module hop_word_deser #(
    parameter int unsigned FRAME_BITS = 26
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       BTE,
    input  logic       START,
    input  logic       HOPD,
    input  logic       HOP_ACK,
    output logic       HOP_VALID,
    output logic [2:0] IM,
    output logic [3:0] IS,
    output logic       SYL,
    output logic [7:0] IA,
    output logic [2:0] DM,
    output logic [3:0] DS,
    output logic       DUPIN,
    output logic       DUPDN,
    output logic       BUSY,
    output logic       OVERRUN,
    output logic       FRAME_ERR,
    output logic       PAR_ERR
);

`ifdef HOP_PARITY_EN
    localparam int unsigned NBITS = FRAME_BITS + 1;
`else
    localparam int unsigned NBITS = FRAME_BITS;
`endif
    localparam logic [4:0] LAST = 5'(NBITS - 1);

    typedef enum logic {StIdle, StShift} state_e;

    state_e             state_q;
    logic [4:0]         cnt_q;
    logic [NBITS-1:0]   shreg_q;
    logic [24:0]        hold_q;
    logic               valid_q;
    logic               overrun_q;
    logic               frame_err_q;
`ifdef HOP_PARITY_EN
    logic               par_err_q;
`endif

    logic [NBITS-1:0]   word_full;
    logic               commit;

    // Shift register with the bit currently on HOPD dropped into its slot.
    always_comb begin
        word_full        = shreg_q;
        word_full[cnt_q] = HOPD;
        commit           = (state_q == StShift) && BTE && !START && (cnt_q == LAST);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= StIdle;
            cnt_q       <= 5'd0;
            shreg_q     <= '0;
            hold_q      <= '0;
            valid_q     <= 1'b0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
`ifdef HOP_PARITY_EN
            par_err_q   <= 1'b0;
`endif
        end else begin
            frame_err_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (BTE && START) begin
                        shreg_q <= {{(NBITS-1){1'b0}}, HOPD};
                        cnt_q   <= 5'd1;
                        state_q <= StShift;
                    end
                end
                StShift: begin
                    if (BTE) begin
                        if (START) begin
                            // Restart: partial frame is discarded, HOPD is the new bit 0.
                            shreg_q     <= {{(NBITS-1){1'b0}}, HOPD};
                            cnt_q       <= 5'd1;
                            frame_err_q <= 1'b1;
                        end else if (cnt_q == LAST) begin
                            shreg_q <= word_full;
                            cnt_q   <= 5'd0;
                            state_q <= StIdle;
                        end else begin
                            shreg_q <= word_full;
                            cnt_q   <= cnt_q + 5'd1;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase

            if (commit) begin
                if (!valid_q || HOP_ACK) begin
                    hold_q    <= word_full[24:0];
                    valid_q   <= 1'b1;
                    overrun_q <= 1'b0;
`ifdef HOP_PARITY_EN
                    par_err_q <= ~(^word_full);
`endif
                end else begin
                    overrun_q <= 1'b1;
                end
            end else if (HOP_ACK && valid_q) begin
                valid_q   <= 1'b0;
                overrun_q <= 1'b0;
            end
        end
    end

    assign HOP_VALID = valid_q;
    assign IM        = hold_q[2:0];
    assign IS        = hold_q[6:3];
    assign SYL       = hold_q[7];
    assign IA        = hold_q[15:8];
    assign DM        = hold_q[18:16];
    assign DS        = hold_q[22:19];
    assign DUPIN     = hold_q[23];
    assign DUPDN     = hold_q[24];
    assign BUSY      = (state_q == StShift);
    assign OVERRUN   = overrun_q;
    assign FRAME_ERR = frame_err_q;
`ifdef HOP_PARITY_EN
    assign PAR_ERR   = par_err_q;
`else
    assign PAR_ERR   = 1'b0;
`endif

endmodule
